// File: rtl/alu_4bit_struct_if.sv
// Operand/result bundle for the 4-bit structural ALU slice.
// The master drives operands and opcode. The slave returns the registered result.
interface alu_4bit_struct_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [1:0] S;
  logic [3:0] F;
  logic       Cout;

  modport master (output A, B, Cin, S, input F, Cout);
  modport slave  (input A, B, Cin, S, output F, Cout);
endinterface

// File: rtl/alu_4bit_struct.sv
// Registered 4-bit ALU slice (AND/OR/XOR/ADD) built from gate primitives.
// It uses a ripple-carry adder, a gate-level 4:1 mux per bit and one 5-bit output register.

module alu_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  logic axb, ab, cx;

  xor g_x1 (axb, a, b);
  xor g_x2 (sum, axb, c);
  and g_a1 (ab, a, b);
  and g_a2 (cx, c, axb);
  or  g_o1 (carry, ab, cx);
endmodule

module alu_mux4 (
  input  logic [1:0] sel,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  output logic       y
);
  logic n0, n1, t0, t1, t2, t3;

  not g_n0 (n0, sel[0]);
  not g_n1 (n1, sel[1]);
  and g_t0 (t0, n1, n0, d0);
  and g_t1 (t1, n1, sel[0], d1);
  and g_t2 (t2, sel[1], n0, d2);
  and g_t3 (t3, sel[1], sel[0], d3);
  or  g_y  (y, t0, t1, t2, t3);
endmodule

module alu_4bit_struct (
  input  logic               clk,
  input  logic               rst_n,
  alu_4bit_struct_if.slave   bus
);
  logic [4:0] carry;
  logic [3:0] sum_bits;
  logic [3:0] and_bits;
  logic [3:0] or_bits;
  logic [3:0] xor_bits;
  logic [3:0] f_comb;
  logic       cout_comb;
  logic [4:0] result_q;

  assign carry[0] = bus.Cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    alu_fa u_fa (
      .a     (bus.A[i]),
      .b     (bus.B[i]),
      .c     (carry[i]),
      .sum   (sum_bits[i]),
      .carry (carry[i+1])
    );

    and g_and (and_bits[i], bus.A[i], bus.B[i]);
    or  g_or  (or_bits[i],  bus.A[i], bus.B[i]);
    xor g_xor (xor_bits[i], bus.A[i], bus.B[i]);

    alu_mux4 u_mux (
      .sel (bus.S),
      .d0  (and_bits[i]),
      .d1  (or_bits[i]),
      .d2  (xor_bits[i]),
      .d3  (sum_bits[i]),
      .y   (f_comb[i])
    );
  end

  // The carry-out is only meaningful for ADD (S=11), so it is forced to 0 for the logic ops.
  and g_cout (cout_comb, bus.S[1], bus.S[0], carry[4]);

  // NOTE: reset is sampled on the clock edge (synchronous). Nonblocking assignment keeps every register update on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= {cout_comb, f_comb};
  end

  assign bus.F    = result_q[3:0];
  assign bus.Cout = result_q[4];
endmodule

// File: tb/tb_alu_4bit_struct.sv
// Self-checking bench for alu_4bit_struct. The bench compares results against a plain-arithmetic reference model,
// using directed vectors, an exhaustive sweep and random stimulus.
module tb_alu_4bit_struct;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  alu_4bit_struct_if bus ();

  alu_4bit_struct dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic cin, input logic [1:0] s);
    int total;
    case (s)
      2'd0:    return {1'b0, a & b};
      2'd1:    return {1'b0, a | b};
      2'd2:    return {1'b0, a ^ b};
      default: begin
        total = int'(a) + int'(b) + int'(cin);
        return 5'(total);
      end
    endcase
  endfunction

  // Drive inputs away from the edge, let one rising edge capture them, then sample 1 time unit later.
  task automatic cycle(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic [1:0] s);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Cin = cin; bus.S = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(4'hF, 4'hF, 1'b1, 2'b11);
      checks++;
      if ({bus.Cout, bus.F} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got Cout=%b F=%b, want Cout=0 F=0000", i, bus.Cout, bus.F);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'hF, 4'hF, 1'b1, 2'b11);
    checks++;
    if ({bus.Cout, bus.F} !== 5'b1_1111) begin
      errors++;
      $display("FAIL reset_release: got Cout=%b F=%b, want Cout=1 F=1111", bus.Cout, bus.F);
    end
  endtask

  task automatic test_add_vectors();
    logic [3:0] av [5] = '{4'b0001, 4'b0101, 4'b1111, 4'b1000, 4'b1111};
    logic [3:0] bv [5] = '{4'b0011, 4'b1010, 4'b0001, 4'b0111, 4'b1111};
    logic       cv [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0] ev [5] = '{5'b0_0100, 5'b0_1111, 5'b1_0000, 5'b0_1111, 5'b1_1111};
    for (int i = 0; i < 5; i++) begin
      cycle(av[i], bv[i], cv[i], 2'b11);
      checks++;
      if ({bus.Cout, bus.F} !== ev[i]) begin
        errors++;
        $display("FAIL add_vec[%0d]: got {Cout,F}=%b, want %b", i, {bus.Cout, bus.F}, ev[i]);
      end
    end
  endtask

  task automatic test_logic_ops();
    logic [4:0] ev [3] = '{5'b0_1000, 5'b0_1110, 5'b0_0110};
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1100, 4'b1010, 1'b1, 2'(i));
      checks++;
      if ({bus.Cout, bus.F} !== ev[i]) begin
        errors++;
        $display("FAIL logic_op S=%0d: got {Cout,F}=%b, want %b", i, {bus.Cout, bus.F}, ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] s;
    logic [4:0] exp;
    for (int i = 0; i < 8; i++) begin
      s   = (i % 2 == 0) ? 2'b11 : 2'b00;
      exp = (i % 2 == 0) ? 5'b0_1000 : 5'b0_0001;
      cycle(4'b0111, 4'b0001, 1'b0, s);
      checks++;
      if ({bus.Cout, bus.F} !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got {Cout,F}=%b, want %b", i, {bus.Cout, bus.F}, exp);
      end
    end
  endtask

  task automatic test_carry_edge();
    cycle(4'b0000, 4'b1111, 1'b1, 2'b11);
    checks++;
    if ({bus.Cout, bus.F} !== 5'b1_0000) begin
      errors++;
      $display("FAIL carry_ripple_cin1: got {Cout,F}=%b, want 10000", {bus.Cout, bus.F});
    end
    cycle(4'b0000, 4'b1111, 1'b0, 2'b11);
    checks++;
    if ({bus.Cout, bus.F} !== 5'b0_1111) begin
      errors++;
      $display("FAIL carry_ripple_cin0: got {Cout,F}=%b, want 01111", {bus.Cout, bus.F});
    end
  endtask

  task automatic test_exhaustive();
    logic [10:0] v;
    logic [4:0]  exp;
    for (int i = 0; i < 2048; i++) begin
      v   = 11'(i);
      exp = ref_model(v[10:7], v[6:3], v[2], v[1:0]);
      cycle(v[10:7], v[6:3], v[2], v[1:0]);
      checks++;
      if ({bus.Cout, bus.F} !== exp) begin
        errors++;
        $display("FAIL exhaustive A=%b B=%b Cin=%b S=%b: got {Cout,F}=%b, want %b",
                 v[10:7], v[6:3], v[2], v[1:0], {bus.Cout, bus.F}, exp);
      end
    end
    // Assert reset with a nonzero result pending. Nothing of that result may survive.
    @(negedge clk);
    rst_n = 1'b0;
    cycle(4'hF, 4'hF, 1'b1, 2'b11);
    checks++;
    if ({bus.Cout, bus.F} !== 5'b0) begin
      errors++;
      $display("FAIL midstream_reset: got {Cout,F}=%b, want 00000", {bus.Cout, bus.F});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] a, b;
    logic       cin;
    logic [1:0] s;
    logic [4:0] exp;
    for (int i = 0; i < 300; i++) begin
      a   = 4'($urandom);
      b   = 4'($urandom);
      cin = 1'($urandom);
      s   = 2'($urandom);
      exp = ref_model(a, b, cin, s);
      cycle(a, b, cin, s);
      checks++;
      if ({bus.Cout, bus.F} !== exp) begin
        errors++;
        $display("FAIL random[%0d] A=%b B=%b Cin=%b S=%b: got {Cout,F}=%b, want %b",
                 i, a, b, cin, s, {bus.Cout, bus.F}, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.S = '0;
    test_reset();
    test_add_vectors();
    test_logic_ops();
    test_back_to_back();
    test_carry_edge();
    test_exhaustive();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
